piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single-bit serial line, one bit per clk, with a qualifying bit_valid strobe.
- Produces the bit stream that downstream D-flip-flop capture chains sample on posedge clk.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, word length in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  parallel word; sampled only on handshake.
- load_valid  input  1  upstream has a word on data_in.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  registered serial data bit.
- bit_valid  output  1  serial_out carries a valid data bit.
- last_bit  output  1  serial_out carries the final bit of the current word.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - state = IDLE, shift register = 0, bit counter = 0.
  - serial_out = 0, bit_valid = 0, last_bit = 0.
  - load_ready = 1 (combinational from state).
- States: IDLE, SHIFT.
- Internal registers:
  - WIDTH-bit shift register.
  - Down-counter cnt of width $clog2(WIDTH), holding the bits remaining after the one currently on serial_out.
- load_ready = (state == IDLE) || (state == SHIFT && cnt == 0). It is combinational and does not depend on load_valid.
- Handshake occurs at a posedge where load_valid && load_ready. At that edge:
  - serial_out <= first bit (data_in[WIDTH-1] if MSB_FIRST, else data_in[0]).
  - Shift register <= the remaining bits.
  - cnt <= WIDTH-1, bit_valid <= 1, last_bit <= 0, state <= SHIFT.
- Latency: the first bit appears on serial_out the cycle after the handshake edge. A word occupies exactly WIDTH consecutive bit_valid cycles.
- SHIFT with cnt > 0, at each posedge:
  - serial_out <= next bit, shift register shifts one position, cnt <= cnt-1.
  - last_bit <= (cnt == 1).
  - load_valid is ignored (load_ready = 0). data_in is not sampled.
- SHIFT with cnt == 0 (last bit on the line, last_bit = 1):
  - If load_valid: a handshake occurs and the next word starts on the following cycle. bit_valid stays 1, with no gap.
  - Else: serial_out <= 0, bit_valid <= 0, last_bit <= 0, state <= IDLE.
- serial_out is 0 whenever bit_valid is 0.
- Reset mid-word: the partial word is discarded with no completion and no last_bit. After rst_n deasserts, the block is in IDLE and accepts a new word normally.
- load_valid held continuously: words stream back-to-back indefinitely, one accepted every WIDTH cycles.
- No combinational path from data_in to serial_out.

Test Plan:
- Reset check: assert rst_n = 0 asynchronously between edges -> serial_out = 0, bit_valid = 0, last_bit = 0, load_ready = 1 immediately, with no clk edge required.
- MSB-first word: WIDTH = 8, MSB_FIRST = 1, load 0xB4 -> on cycles 1..8 after the handshake:
  - serial_out = 1,0,1,1,0,1,0,0.
  - bit_valid high for all 8 cycles.
  - last_bit high only on cycle 8.
  - load_ready low on cycles 1..7 and high on cycle 8.
  - Cycle 9: bit_valid = 0, serial_out = 0.
- LSB-first word: MSB_FIRST = 0, load 0x0F -> serial_out = 1,1,1,1,0,0,0,0, last_bit on the 8th bit.
- Back-to-back: load_valid held high with 0xF0 then 0x3C (MSB first) -> 16 contiguous bit_valid cycles:
  - Stream 1111000000111100.
  - last_bit on cycles 8 and 16.
  - Second handshake occurs on the cycle-8 edge.
- Busy-ignore: during word 0x81, assert load_valid with data_in = 0xFF on cycles 2..6 -> stream stays 10000001. 0xFF is accepted only at cycle 8 and then streamed as 11111111.
- Reset mid-word: start 0xAA, pull rst_n low after 3 bits -> outputs clear immediately and no last_bit is seen. After release, loading 0x81 streams 10000001 cleanly.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load handshake and serial line bundle between an upstream word source and piso_serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             bit_valid;
  logic             last_bit;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  serial_out,
    input  bit_valid,
    input  last_bit
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output serial_out,
    output bit_valid,
    output last_bit
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word per handshake, one bit per clk,
// with back-to-back words streamed without an idle gap.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  piso_serializer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             sout_q,  sout_d;
  logic             bv_q,    bv_d;
  logic             lb_q,    lb_d;
  logic             load_ready_c;
  logic             load_c;

  // Bit that leaves first from a word or from the remaining shift contents.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Remaining bits once the leading bit has been sent.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready while idle or while the last bit of the current word is on the line.
  assign load_ready_c = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0));
  assign load_c       = bus.load_valid && load_ready_c;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    bv_d    = bv_q;
    lb_d    = lb_q;

    case (state_q)
      IDLE: begin
        if (load_c) begin
          sout_d  = first_bit(bus.data_in);
          sreg_d  = advance(bus.data_in);
          cnt_d   = CNT_W'(WIDTH - 1);
          bv_d    = 1'b1;
          lb_d    = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sout_d = first_bit(sreg_q);
          sreg_d = advance(sreg_q);
          cnt_d  = cnt_q - CNT_W'(1);
          lb_d   = (cnt_q == CNT_W'(1));
        end else if (load_c) begin
          sout_d  = first_bit(bus.data_in);
          sreg_d  = advance(bus.data_in);
          cnt_d   = CNT_W'(WIDTH - 1);
          bv_d    = 1'b1;
          lb_d    = 1'b0;
          state_d = SHIFT;
        end else begin
          sout_d  = 1'b0;
          bv_d    = 1'b0;
          lb_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        sout_d  = 1'b0;
        bv_d    = 1'b0;
        lb_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      bv_q    <= 1'b0;
      lb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      bv_q    <= bv_d;
      lb_q    <= lb_d;
    end
  end

  assign bus.load_ready = load_ready_c;
  assign bus.serial_out = sout_q;
  assign bus.bit_valid  = bv_q;
  assign bus.last_bit   = lb_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Drives an MSB-first and an LSB-first serializer with identical stimulus and checks both
// against a bit-queue reference model every cycle, plus directed whole-stream checks.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;

  piso_serializer_if #(.WIDTH(W)) bm ();
  piso_serializer_if #(.WIDTH(W)) bl ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bm));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bl));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic         vld;
  logic [W-1:0] din;

  // Reference: bits still to appear on each line, front = bit currently shown.
  bit qm[$];
  bit ql[$];

  logic [63:0] cap_m, cap_l;
  int          cap_n, lb_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    vld = v;
    din = d;
    bm.load_valid = v;
    bl.load_valid = v;
    bm.data_in    = d;
    bl.data_in    = d;
  endtask

  task automatic check_lines();
    chk("m_serial", 64'(bm.serial_out), 64'((qm.size() > 0) ? qm[0] : 1'b0));
    chk("m_valid",  64'(bm.bit_valid),  64'(qm.size() > 0));
    chk("m_last",   64'(bm.last_bit),   64'(qm.size() == 1));
    chk("m_ready",  64'(bm.load_ready), 64'(qm.size() <= 1));
    chk("l_serial", 64'(bl.serial_out), 64'((ql.size() > 0) ? ql[0] : 1'b0));
    chk("l_valid",  64'(bl.bit_valid),  64'(ql.size() > 0));
    chk("l_last",   64'(bl.last_bit),   64'(ql.size() == 1));
    chk("l_ready",  64'(bl.load_ready), 64'(ql.size() <= 1));
  endtask

  // One clock: decide handshake from pre-edge model state, advance model, compare.
  task automatic step();
    bit hs;
    hs = rst_n && vld && (qm.size() <= 1);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (hs) begin
        for (int i = W - 1; i >= 0; i--) qm.push_back(din[i]);
        for (int i = 0; i < W; i++)      ql.push_back(din[i]);
      end
    end
    check_lines();
    if (bm.bit_valid === 1'b1) begin
      cap_m = {cap_m[62:0], bm.serial_out};
      cap_l = {cap_l[62:0], bl.serial_out};
      cap_n++;
    end
    if (bm.last_bit === 1'b1) lb_cnt++;
  endtask

  task automatic clear_cap();
    cap_m  = '0;
    cap_l  = '0;
    cap_n  = 0;
    lb_cnt = 0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    qm.delete();
    ql.delete();
    #1;
    check_lines();
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, '0);
    clear_cap();

    // Asynchronous reset before any clock edge
    async_reset();
    step();
    step();
    #2 rst_n = 1'b1;
    step();

    // MSB-first 0xB4 / LSB-first view of the same word
    clear_cap();
    drive(1'b1, 8'hB4);
    step();
    drive(1'b0, 8'h00);
    repeat (8) step();
    chk("b4_msb_stream", cap_m, 64'hB4);
    chk("b4_lsb_stream", cap_l, 64'h2D);
    chk("b4_bits", 64'(cap_n), 64'd8);
    chk("b4_last_cnt", 64'(lb_cnt), 64'd1);

    // 0x0F: LSB-first line shows 1,1,1,1,0,0,0,0
    clear_cap();
    drive(1'b1, 8'h0F);
    step();
    drive(1'b0, 8'h00);
    repeat (8) step();
    chk("0f_msb_stream", cap_m, 64'h0F);
    chk("0f_lsb_stream", cap_l, 64'hF0);

    // Back-to-back 0xF0 then 0x3C with load_valid held
    clear_cap();
    drive(1'b1, 8'hF0);
    step();
    drive(1'b1, 8'h3C);
    repeat (8) step();
    drive(1'b0, 8'h00);
    repeat (8) step();
    chk("b2b_msb_stream", cap_m, 64'hF03C);
    chk("b2b_lsb_stream", cap_l, 64'h0F3C);
    chk("b2b_bits", 64'(cap_n), 64'd16);
    chk("b2b_last_cnt", 64'(lb_cnt), 64'd2);

    // Busy-ignore: 0xFF offered throughout 0x81, accepted only on its last bit
    clear_cap();
    drive(1'b1, 8'h81);
    step();
    drive(1'b1, 8'hFF);
    repeat (8) step();
    drive(1'b0, 8'h00);
    repeat (8) step();
    chk("busy_msb_stream", cap_m, 64'h81FF);
    chk("busy_lsb_stream", cap_l, 64'h81FF);
    chk("busy_bits", 64'(cap_n), 64'd16);

    // Reset mid-word: 0xAA cut after 3 bits, then a clean 0x81
    clear_cap();
    drive(1'b1, 8'hAA);
    step();
    drive(1'b0, 8'h00);
    step();
    step();
    async_reset();
    chk("rst_bits_seen", 64'(cap_n), 64'd3);
    step();
    chk("rst_no_last", 64'(lb_cnt), 64'd0);
    #2 rst_n = 1'b1;
    clear_cap();
    drive(1'b1, 8'h81);
    step();
    drive(1'b0, 8'h00);
    repeat (8) step();
    chk("after_rst_msb", cap_m, 64'h81);
    chk("after_rst_lsb", cap_l, 64'h81);
    chk("after_rst_last", 64'(lb_cnt), 64'd1);

    // Random traffic with bursty load_valid
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom));
      step();
    end
    drive(1'b0, 8'h00);
    repeat (W + 2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
